// File: rtl/serial_unary_or.sv
// Bit-serial OR reduction: accepts an N-bit operand, folds W bits per cycle, returns |a.
// Optional build macro SERIAL_UNARY_OR_EARLY_EXIT_EN finishes on the first nonzero chunk.
module serial_unary_or #(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [N-1:0] a,
  output logic         c_valid,
  input  logic         c_ready,
  output logic         c,
  output logic         busy
);

  localparam int STEPS = N / W;
  localparam int CW    = $clog2(STEPS) + 1;

  generate
    if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
      $error("serial_unary_or: need 1 <= W <= N and N %% W == 0 (N=%0d W=%0d)", N, W);
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nx;
  logic [N-1:0]   sh;
  logic           acc;
  logic [CW-1:0]  cnt;
  logic           chunk_or;
  logic           last;

  assign chunk_or = |sh[W-1:0];
  assign last     = (cnt == CW'(STEPS - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (a_valid) state_nx = SCAN;
      SCAN: begin
`ifdef SERIAL_UNARY_OR_EARLY_EXIT_EN
        if (chunk_or || acc || last) state_nx = DONE;
`else
        if (last) state_nx = DONE;
`endif
      end
      DONE:    if (c_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      acc   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (a_valid) begin
            sh  <= a;
            acc <= 1'b0;
            cnt <= '0;
          end
        end
        SCAN: begin
          // On an early exit this same fold sets acc, so c is 1 in DONE.
          acc <= acc | chunk_or;
          sh  <= sh >> W;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign a_ready = (state == IDLE);
  assign c_valid = (state == DONE);
  assign c       = acc;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_serial_unary_or.sv
// Directed and randomised checks of serial_unary_or over four (N,W) instances sharing clk/rst.
// Expected latencies follow SERIAL_UNARY_OR_EARLY_EXIT_EN when the build defines it.
module tb_serial_unary_or;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid_in = 1'b0;
  int          av_sel = 0;
  logic [3:0]  av;
  logic [31:0] a_bus = '0;
  logic        c_ready = 1'b0;
  logic [3:0]  a_ready, c_valid, c, busy;

  int checks = 0;
  int errors = 0;
  int hs [4] = '{0, 0, 0, 0};

  // Instance geometry: 0 = N8/W1, 1 = N16/W4, 2 = N1/W1, 3 = N32/W8
  int nn [4] = '{8, 16, 1, 32};
  int ww [4] = '{1, 4, 1, 8};

  always #5 clk = ~clk;

  always_comb begin
    av = '0;
    av[av_sel] = a_valid_in;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (av[i] && a_ready[i]) hs[i] = hs[i] + 1;
  end

  serial_unary_or #(.N(8), .W(1)) u_n8 (
    .clk(clk), .rst(rst), .a_valid(av[0]), .a_ready(a_ready[0]), .a(a_bus[7:0]),
    .c_valid(c_valid[0]), .c_ready(c_ready), .c(c[0]), .busy(busy[0]));
  serial_unary_or #(.N(16), .W(4)) u_n16 (
    .clk(clk), .rst(rst), .a_valid(av[1]), .a_ready(a_ready[1]), .a(a_bus[15:0]),
    .c_valid(c_valid[1]), .c_ready(c_ready), .c(c[1]), .busy(busy[1]));
  serial_unary_or #(.N(1), .W(1)) u_n1 (
    .clk(clk), .rst(rst), .a_valid(av[2]), .a_ready(a_ready[2]), .a(a_bus[0:0]),
    .c_valid(c_valid[2]), .c_ready(c_ready), .c(c[2]), .busy(busy[2]));
  serial_unary_or #(.N(32), .W(8)) u_n32 (
    .clk(clk), .rst(rst), .a_valid(av[3]), .a_ready(a_ready[3]), .a(a_bus[31:0]),
    .c_valid(c_valid[3]), .c_ready(c_ready), .c(c[3]), .busy(busy[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_lat(input int sel, input logic [31:0] v);
    int steps;
    steps = nn[sel] / ww[sel];
`ifdef SERIAL_UNARY_OR_EARLY_EXIT_EN
    for (int k = 0; k < steps; k++)
      if (((v >> (k * ww[sel])) & ((32'd1 << ww[sel]) - 32'd1)) != 0) return k + 1;
`endif
    return steps;
  endfunction

  function automatic logic [31:0] width_mask(input int sel);
    logic [63:0] m;
    m = (64'd1 << nn[sel]) - 64'd1;
    return m[31:0];
  endfunction

  // Accept one operand with c_ready held high; a is scrambled after the accept edge.
  task automatic run_op(input int sel, input logic [31:0] v, input logic exp_c,
                        input int exp_lat, input string name);
    int edges;
    @(negedge clk);
    av_sel = sel; a_bus = v; a_valid_in = 1'b1; c_ready = 1'b1;
    @(negedge clk);
    a_valid_in = 1'b0; a_bus = ~v;
    edges = 0;
    while (!c_valid[sel] && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check({name, " latency"}, edges, exp_lat);
    check({name, " c"}, c[sel], exp_c);
    @(negedge clk);
    check({name, " back to idle"}, {a_ready[sel], busy[sel], c_valid[sel]}, 3'b100);
  endtask

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] a;
    logic        exp_c;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  initial begin
    vec_t vecs [12];
    int   edges, h0, lat;
    logic stable;
    logic [31:0] v;

    vecs[0]  = '{"n8 00",       0, 32'h00,        1'b0, 8, 8};
    vecs[1]  = '{"n8 80",       0, 32'h80,        1'b1, 8, 8};
    vecs[2]  = '{"n8 01",       0, 32'h01,        1'b1, 8, 1};
    vecs[3]  = '{"n8 10",       0, 32'h10,        1'b1, 8, 5};
    vecs[4]  = '{"n16 0100",    1, 32'h0100,      1'b1, 4, 3};
    vecs[5]  = '{"n16 0000",    1, 32'h0000,      1'b0, 4, 4};
    vecs[6]  = '{"n16 000f",    1, 32'h000F,      1'b1, 4, 1};
    vecs[7]  = '{"n1 1",        2, 32'h1,         1'b1, 1, 1};
    vecs[8]  = '{"n1 0",        2, 32'h0,         1'b0, 1, 1};
    vecs[9]  = '{"n32 f0000000",3, 32'hF000_0000, 1'b1, 4, 4};
    vecs[10] = '{"n32 0",       3, 32'h0,         1'b0, 4, 4};
    vecs[11] = '{"n32 00000100",3, 32'h0000_0100, 1'b1, 4, 2};

    // Reset values
    #12;
    check("reset a_ready", a_ready, 4'hF);
    check("reset c_valid", c_valid, 4'h0);
    check("reset c", c, 4'h0);
    check("reset busy", busy, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
`ifdef SERIAL_UNARY_OR_EARLY_EXIT_EN
      lat = vecs[i].lat_early;
`else
      lat = vecs[i].lat_fixed;
`endif
      run_op(vecs[i].sel, vecs[i].a, vecs[i].exp_c, lat, vecs[i].name);
    end

    // Backpressure: DONE holds c and c_valid while c_ready is low
    @(negedge clk);
    av_sel = 0; a_bus = 32'h00; a_valid_in = 1'b1; c_ready = 1'b0;
    @(negedge clk);
    a_valid_in = 1'b0;
    edges = 0;
    while (!c_valid[0] && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("bp latency", edges, 8);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (c_valid[0] !== 1'b1 || c[0] !== 1'b0 || a_ready[0] !== 1'b0) stable = 1'b0;
    end
    check("bp hold stable", stable, 1'b1);
    c_ready = 1'b1;
    @(negedge clk);
    check("bp release", {a_ready[0], c_valid[0], busy[0]}, 3'b100);

    // Async reset in flight: outputs drop at once, operand discarded
    @(negedge clk);
    av_sel = 0; a_bus = 32'hFF; a_valid_in = 1'b1; c_ready = 1'b0;
    @(posedge clk);
    #1 a_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst outputs", {a_ready[0], c_valid[0], c[0], busy[0]}, 4'b1000);
    @(negedge clk);
    rst = 1'b0;
    c_ready = 1'b1;
    stable = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (c_valid[0] !== 1'b0 || busy[0] !== 1'b0) stable = 1'b0;
    end
    check("midrst no result", stable, 1'b1);
    run_op(0, 32'h00, 1'b0, 8, "post rst 00");

    // a_valid held and a toggled while busy: one accept, result from sampled operand
    @(negedge clk);
    h0 = hs[0];
    av_sel = 0; a_bus = 32'h00; a_valid_in = 1'b1; c_ready = 1'b0;
    edges = 0;
    @(negedge clk);
    while (!c_valid[0] && edges < 100) begin
      a_bus = ~a_bus;
      @(negedge clk);
      edges++;
    end
    check("toggle latency", edges, 8);
    check("toggle c", c[0], 1'b0);
    check("toggle accepts", hs[0] - h0, 1);
    a_valid_in = 1'b0; c_ready = 1'b1;
    @(negedge clk);
    check("toggle idle", a_ready[0], 1'b1);

    // Throughput on N16/W4 with both handshakes tied high: one accept per 6 cycles
    @(negedge clk);
    h0 = hs[1];
    av_sel = 1; a_bus = 32'h0; a_valid_in = 1'b1; c_ready = 1'b1;
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("throughput accepts", hs[1] - h0, 4);
    a_valid_in = 1'b0;
    edges = 0;
    while (busy[1] && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check("throughput drain", busy[1], 1'b0);

    // Randomised operands on N in {1, 8, 32}
    for (int i = 0; i < 1000; i++) begin
      int sel, r;
      r = $urandom_range(0, 2);
      sel = (r == 0) ? 2 : (r == 1) ? 0 : 3;
      r = $urandom_range(0, 3);
      if (r == 0)      v = 32'h0;
      else if (r == 1) v = 32'd1 << $urandom_range(0, nn[sel] - 1);
      else             v = $urandom;
      v = v & width_mask(sel);
      run_op(sel, v, |v, model_lat(sel, v), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
